// File: rtl/clock_divider_v3.sv
// clock_divider_v3: multi-channel programmable clock divider.
// Each channel divides ref_clk by a runtime-programmable divisor N, producing a
// registered divided clock (clk_out), a one-cycle strobe at each clk_out rising
// edge (tick), and a status bit (active). New divisors are staged in a pending
// register and only take effect at a period boundary (wrap) or at a sync pulse,
// so clk_out never produces a runt pulse. A global sync pulse restarts every
// running channel at count 0 on the same edge.
//
// Optional feature, macro CLKDIV_DUTY_EN: adds the cfg_high input and a
// per-channel programmable high time that is staged and applied together with
// the divisor. Without the macro the high time is fixed at floor(N/2).
//
// Config port: cfg_we is a single-cycle write strobe with no back-pressure;
// every edge with cfg_we high and cfg_ch < NUM_CH is accepted.
module clock_divider_v3 #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 1000
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0]  cfg_high,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active
);

    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] HIGH_INIT = CNT_W'(DIV_DEFAULT / 2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Per-channel state
        logic [CNT_W-1:0] count_q, count_d;
        logic [CNT_W-1:0] active_div_q, active_div_d;
        logic [CNT_W-1:0] pending_div_q, pending_div_d;
        logic             pend_valid_q, pend_valid_d;
        logic             clk_out_q, clk_out_d;
        logic             tick_q, tick_d;
        logic             active_q, active_d;
`ifdef CLKDIV_DUTY_EN
        logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
        logic [CNT_W-1:0] pending_high_q, pending_high_d;
`endif

        // Intermediate decode
        logic             running;
        logic             restart;
        logic             we_hit;
        logic [CNT_W-1:0] count_next;
        logic [CNT_W-1:0] high_thresh;

        // Next-state: counter advance, staged divisor apply and output decode
        always_comb begin
            count_d        = count_q;
            active_div_d   = active_div_q;
            pending_div_d  = pending_div_q;
            pend_valid_d   = pend_valid_q;
            clk_out_d      = 1'b0;
            tick_d         = 1'b0;
            active_d       = 1'b0;
`ifdef CLKDIV_DUTY_EN
            high_cnt_d     = high_cnt_q;
            pending_high_d = pending_high_q;
`endif
            count_next     = '0;
            high_thresh    = '0;

            running = ch_en[g] && (active_div_q >= TWO);
            restart = sync || (count_q == (active_div_q - ONE));
            we_hit  = cfg_we && (cfg_ch == 4'(g));

            if (!running) begin
                // Stopped: a staged divisor is absorbed immediately, and the
                // counter parks at N-1 of the divisor in force next cycle so
                // that the first enabled edge is a wrap to count 0.
                if (pend_valid_q) begin
                    active_div_d = pending_div_q;
                    pend_valid_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
                    high_cnt_d   = pending_high_q;
`endif
                end
                count_d = active_div_d - ONE;
            end else begin
                count_next = restart ? '0 : (count_q + ONE);
                // The staged divisor governs the period that begins at count 0
                if (restart && pend_valid_q) begin
                    active_div_d = pending_div_q;
                    pend_valid_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
                    high_cnt_d   = pending_high_q;
`endif
                end
                count_d = count_next;
`ifdef CLKDIV_DUTY_EN
                high_thresh = high_cnt_d;
`else
                high_thresh = active_div_d >> 1;
`endif
                // A newly applied divisor of 0 or 1 stops the channel at once
                if (active_div_d >= TWO) begin
                    clk_out_d = (count_next < high_thresh);
                    tick_d    = (count_next == '0);
                    active_d  = 1'b1;
                end
            end

            // A write lands in the staging register only; it never takes
            // effect on the edge it is made, even if that edge is a wrap.
            if (we_hit) begin
                pending_div_d  = cfg_div;
                pend_valid_d   = 1'b1;
`ifdef CLKDIV_DUTY_EN
                pending_high_d = cfg_high;
`endif
            end
        end

        // State and registered outputs, asynchronously cleared by reset
        always_ff @(posedge ref_clk or negedge reset) begin
            if (!reset) begin
                count_q        <= DIV_INIT - ONE;
                active_div_q   <= DIV_INIT;
                pending_div_q  <= DIV_INIT;
                pend_valid_q   <= 1'b0;
                clk_out_q      <= 1'b0;
                tick_q         <= 1'b0;
                active_q       <= 1'b0;
`ifdef CLKDIV_DUTY_EN
                high_cnt_q     <= HIGH_INIT;
                pending_high_q <= HIGH_INIT;
`endif
            end else begin
                count_q        <= count_d;
                active_div_q   <= active_div_d;
                pending_div_q  <= pending_div_d;
                pend_valid_q   <= pend_valid_d;
                clk_out_q      <= clk_out_d;
                tick_q         <= tick_d;
                active_q       <= active_d;
`ifdef CLKDIV_DUTY_EN
                high_cnt_q     <= high_cnt_d;
                pending_high_q <= pending_high_d;
`endif
            end
        end

        assign clk_out[g] = clk_out_q;
        assign tick[g]    = tick_q;
        assign active[g]  = active_q;
    end

`ifndef CLKDIV_DUTY_EN
    // High time is derived from the divisor in this build
    logic unused_high_init;
    assign unused_high_init = ^HIGH_INIT;
`endif

endmodule

// File: doc/clock_divider_v3.md
Name: clock_divider_v3

Overview:
- Multi-channel, runtime-programmable successor to the fixed single-output clock divider.
- Each channel derives a divided clock and a one-cycle tick strobe from ref_clk, with a per-channel divisor set over a small config write port.
- Divisor changes are glitch-free, and a global sync input phase-aligns all channels.
- Sits between the board reference clock and the camera, servo and timing logic that currently use separate fixed dividers.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 16, width of the divisor and of each channel counter.
- DIV_DEFAULT, 1000, divisor loaded into every channel at reset (100 MHz to 100 kHz).

Ports:
- ref_clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync  in  1  one-cycle pulse; restarts all enabled channels in phase.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  4  target channel index for the write.
- cfg_div  in  CNT_W  new divisor N.
- clk_out  out  NUM_CH  divided clock per channel, registered.
- tick  out  NUM_CH  one-ref_clk-cycle pulse per channel, coincident with the rising edge of clk_out.
- active  out  NUM_CH  channel enabled and divisor N >= 2.

Behaviour:
- Reset (reset low, asynchronous):
  - active_div and pending_div = DIV_DEFAULT.
  - count = DIV_DEFAULT-1.
  - clk_out, tick and active = 0.
- Per channel state: count[CNT_W], active_div, pending_div, pend_valid.
- Valid divisor, N >= 2:
  - Period is N ref_clk cycles.
  - High for floor(N/2) cycles, low for ceil(N/2); odd N gives a short high phase.
- Stopped channel (ch_en low, or active_div < 2):
  - count held at active_div-1; clk_out = 0, tick = 0, active = 0.
  - If pend_valid, pending_div moves into active_div on the next edge.
- Running channel, each ref_clk edge:
  - wrap is true when count == active_div-1.
  - count_next = wrap ? 0 : count+1.
  - count <= count_next.
  - clk_out <= (count_next < active_div/2).
  - tick <= (count_next == 0).
  - On wrap with pend_valid: active_div <= pending_div and pend_valid clears. The new N governs the cycle that starts at count 0, so there are no runt pulses.
- Latency:
  - First rising edge of clk_out and first tick appear on the first ref_clk edge at which ch_en is sampled high.
  - Dropping ch_en forces clk_out low on the next edge (truncated high phase permitted).
- Config write:
  - On an edge with cfg_we high: pending_div[cfg_ch] <= cfg_div and pend_valid set.
  - A write on the same edge as a wrap is applied at the following wrap, not the current one.
  - A repeated write before application overwrites pending_div; the last write wins.
  - cfg_ch >= NUM_CH: write ignored.
  - cfg_div of 0 or 1: accepted; when applied, the channel stops (active = 0) until a valid divisor is written.
- Sync, on an edge with sync high, for every running channel:
  - Forced count_next = 0, so clk_out <= 1 and tick <= 1.
  - A pending divisor is applied at that same edge.
  - A cfg write on the same edge lands in pending_div only and is not applied by that sync.
  - sync has no effect on stopped channels.
- Channels are fully independent apart from sync. No combinational path from any input to any output.

Optional Feature:
- Macro: CLKDIV_DUTY_EN.
- Defined:
  - Adds input cfg_high [CNT_W] and a per-channel shadow register high_cnt, written with cfg_div and applied at the same wrap or sync.
  - clk_out <= (count_next < high_cnt).
  - high_cnt = 0 gives clk_out held low, with tick still pulsing.
  - high_cnt >= N gives clk_out held high after the first edge, with tick still pulsing.
  - Reset value of high_cnt is DIV_DEFAULT/2.
- Undefined: port absent; fixed floor(N/2) high time as above.

Test Plan:
- Reset release, ch_en=0001, default N=1000 -> clk_out[0] period 1000 cycles, high for 500; tick[0] every 1000 cycles; the first tick occurs on the first edge with ch_en high; other channels stay 0.
- Channel 1 with N=5 -> high 2 cycles, low 3; write N=8 mid-period -> the current 5-cycle period completes, then 4 high / 4 low; no pulse shorter than 2 cycles.
- Channel 2 with N=1000; write cfg_div=1 -> after the next wrap, active[2]=0 and clk_out[2]=0; write N=4 -> the channel resumes with a 2/2 pattern.
- Channels 0..3 with N=6,10,14,1000 running at random phases; sync pulse -> all four tick on the same edge; write cfg_ch=7 -> no channel changes.
- Assert reset mid-high-phase -> outputs drop immediately; after release, every divisor has returned to 1000.
- With CLKDIV_DUTY_EN defined: N=10, cfg_high=3 -> 3 high / 7 low; cfg_high=0 -> clk_out low while tick keeps a 10-cycle period.
